cdm_msg_rsp_tracker: RTL and testbench
======================================

// Module: cdm_msg_rsp_tracker
// PURPOSE
// Consumes the CDM byp_out response stream downstream of the MSG ST/LD order enforcer. Splits responses by
// cookie bit 0 (0 = MSGST write-ack, 1 = MSGLD read data) and counts outstanding requests per type.
// Checks MSGLD data against an expected incrementing pattern and detects orphan responses and stalls.
// Drives a run/drain status FSM so software can tell when traffic has quiesced cleanly.
// PARAMETERS
// OUTS_W      9       width of outstanding/total counters; saturate at 2**OUTS_W-1
// TIMEOUT_W   16      width of stall watchdog counter
// TIMEOUT_CYC 16'hFFFF cycles with outstanding>0 and no matching response before a timeout
// PORTS
// user_clk       in   1         clock
// user_reset     in   1         synchronous active-high reset
// en             in   1         block enable; en=0 acts as synchronous clear of all state
// start          in   1         level: traffic running; falling edge requests drain
// msgst_req_fire in   1         one MSGST request accepted (vld&rdy&eop) this cycle
// msgld_req_fire in   1         one MSGLD request accepted (vld&rdy) this cycle
// rsp_vld        in   1         response beat valid
// rsp_rdy        out  1         response ready; 1 whenever not in reset
// rsp_cookie     in   12        response cookie; only bit 0 decoded
// rsp_dsc        in   16        MSGLD returned data [15:0]
// msgst_outs     out  OUTS_W    MSGST requests awaiting ack
// msgld_outs     out  OUTS_W    MSGLD requests awaiting data
// msgld_rsp_cnt  out  OUTS_W    total MSGLD responses (wraps)
// busy           out  1         FSM in RUN or DRAIN
// done           out  1         FSM in DONE
// err_vec        out  4         sticky: [0] data mismatch [1] orphan rsp [2] timeout [3] counter overflow
// BEHAVIOUR
// - Reset/en=0: all counters 0, expected pattern 16'h0, err_vec 0, FSM IDLE, busy=done=0; rsp_rdy=0 in reset only.
// - Response handshake: rsp_fire = rsp_vld & rsp_rdy; rsp_rdy combinational, no back-pressure otherwise.
// - Outstanding per type: +1 on req_fire, -1 on matching rsp_fire; both same cycle -> unchanged.
// - Orphan: rsp_fire of a type whose outstanding==0 and no same-cycle req of that type -> err_vec[1]; count stays 0.
// - Overflow: req_fire at all-ones without same-cycle response -> err_vec[3]; count holds at max.
// - Data check: on MSGLD rsp_fire compare rsp_dsc to expected; mismatch -> err_vec[0] next cycle;
//   expected increments by 1 (mod 2**16) on every MSGLD rsp_fire regardless of match.
// - Outputs registered; msgst_outs/msgld_outs/msgld_rsp_cnt/err_vec reflect a fire 1 cycle later.
// - Watchdog: counter clears on any rsp_fire or when both outstanding==0; else increments;
//   reaching TIMEOUT_CYC sets err_vec[2] and holds the counter at TIMEOUT_CYC.
// - Errors are sticky until reset/en=0; they never stall the response path.
// FSM (IDLE, RUN, DRAIN, DONE):
//   IDLE -> RUN when start=1. RUN -> DRAIN when start=0.
//   DRAIN -> DONE when msgst_outs==0 and msgld_outs==0 (evaluated on registered values).
//   DRAIN -> DRAIN if timeout fires (err_vec[2] set; stays until reset/en=0 or start=1).
//   DONE -> RUN when start=1. Any state -> RUN when start=1 from DRAIN (traffic resumes).
// - Req fires counted in every state (including IDLE/DONE) so late handshakes are not lost.
// - start toggling mid-drain: return to RUN with counters preserved.
// STRUCTURE
// - Shared package cdm_tg_pkg: MSGST_RESPONSE_COOKIE=12'h0, MSGLD_RESPONSE_COOKIE=12'h1,
//   typedef enum {IDLE,RUN,DRAIN,DONE} trk_state_e, err_vec bit index localparams.
// - One sub-module cdm_outs_counter (param WIDTH): inc/dec/same-cycle/saturate/orphan/overflow;
//   instantiated twice (MSGST, MSGLD). Watchdog, data check and FSM live in the top.
// TESTING
// - 4 MSGLD reqs, responses cookie=1 dsc=0,1,2,3 -> msgld_outs 4->0, msgld_rsp_cnt=4, err_vec=0.
// - MSGLD rsp dsc=0,1,5 -> err_vec[0]=1 the cycle after third beat; next dsc=3 accepted without new error.
// - MSGST rsp cookie=0 with msgst_outs=0 -> err_vec[1]=1, msgst_outs stays 0; same-cycle req+rsp -> no error.
// - TIMEOUT_CYC=16 override, 1 MSGLD req, no rsp -> err_vec[2] set 16 cycles after req; FSM stuck in DRAIN after start=0.
// - start=1, 3 MSGST reqs, start=0, 3 acks -> busy until last ack registered, then done=1; start=1 -> busy=1, done=0.
// - OUTS_W=2, 4 MSGST reqs no acks -> msgst_outs=3, err_vec[3]=1; user_reset=1 one cycle -> all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/cdm_tg_pkg.sv
// Shared definitions for the CDM traffic-generator response tracking logic:
// response cookies, tracker FSM states and sticky error bit positions.
package cdm_tg_pkg;

  localparam logic [11:0] MSGST_RESPONSE_COOKIE = 12'h0;
  localparam logic [11:0] MSGLD_RESPONSE_COOKIE = 12'h1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } trk_state_e;

  localparam int unsigned ERR_DATA    = 0;
  localparam int unsigned ERR_ORPHAN  = 1;
  localparam int unsigned ERR_TIMEOUT = 2;
  localparam int unsigned ERR_OVF     = 3;

endpackage

// File: rtl/cdm_outs_counter.sv
// Saturating outstanding-request counter: +1 per request, -1 per response,
// with orphan (response at zero) and overflow (request at max) pulses.
module cdm_outs_counter #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             orphan_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Simultaneous request and response cancel out, so neither pulse can fire.
  always_comb begin
    cnt_d      = cnt_q;
    orphan_o   = 1'b0;
    overflow_o = 1'b0;
    unique case ({inc_i, dec_i})
      2'b10: begin
        if (cnt_q == '1) overflow_o = 1'b1;
        else             cnt_d      = cnt_q + WIDTH'(1);
      end
      2'b01: begin
        if (cnt_q == '0) orphan_o = 1'b1;
        else             cnt_d    = cnt_q - WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cdm_msg_rsp_tracker.sv
// Tracks MSGST acks / MSGLD data on the CDM byp_out response stream: outstanding
// counts, MSGLD pattern check, stall watchdog and a run/drain status FSM.
module cdm_msg_rsp_tracker
  import cdm_tg_pkg::*;
#(
  parameter int unsigned          OUTS_W      = 9,
  parameter int unsigned          TIMEOUT_W   = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = 16'hFFFF
) (
  input  logic              user_clk,
  input  logic              user_reset,
  input  logic              en,
  input  logic              start,
  input  logic              msgst_req_fire,
  input  logic              msgld_req_fire,
  input  logic              rsp_vld,
  output logic              rsp_rdy,
  input  logic [11:0]       rsp_cookie,
  input  logic [15:0]       rsp_dsc,
  output logic [OUTS_W-1:0] msgst_outs,
  output logic [OUTS_W-1:0] msgld_outs,
  output logic [OUTS_W-1:0] msgld_rsp_cnt,
  output logic              busy,
  output logic              done,
  output logic [3:0]        err_vec
);

  logic clr;
  logic rsp_fire, st_rsp_fire, ld_rsp_fire;
  logic st_orphan, st_ovf, ld_orphan, ld_ovf;
  logic unused_cookie;

  logic [15:0]          exp_q, exp_d;
  logic [OUTS_W-1:0]    rsp_cnt_q, rsp_cnt_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [3:0]           err_q, err_d;
  trk_state_e           state_q, state_d;

  assign clr           = user_reset | ~en;
  assign rsp_rdy       = ~user_reset;
  assign rsp_fire      = rsp_vld & rsp_rdy;
  assign st_rsp_fire   = rsp_fire & (rsp_cookie[0] == MSGST_RESPONSE_COOKIE[0]);
  assign ld_rsp_fire   = rsp_fire & (rsp_cookie[0] == MSGLD_RESPONSE_COOKIE[0]);
  assign unused_cookie = ^rsp_cookie[11:1];

  cdm_outs_counter #(.WIDTH(OUTS_W)) u_msgst_outs (
    .clk_i      (user_clk),
    .clr_i      (clr),
    .inc_i      (msgst_req_fire),
    .dec_i      (st_rsp_fire),
    .cnt_o      (msgst_outs),
    .orphan_o   (st_orphan),
    .overflow_o (st_ovf)
  );

  cdm_outs_counter #(.WIDTH(OUTS_W)) u_msgld_outs (
    .clk_i      (user_clk),
    .clr_i      (clr),
    .inc_i      (msgld_req_fire),
    .dec_i      (ld_rsp_fire),
    .cnt_o      (msgld_outs),
    .orphan_o   (ld_orphan),
    .overflow_o (ld_ovf)
  );

  always_comb begin
    exp_d     = exp_q;
    rsp_cnt_d = rsp_cnt_q;
    err_d     = err_q;
    wd_d      = wd_q;

    // The expected pattern advances on every MSGLD beat, matched or not.
    if (ld_rsp_fire) begin
      exp_d     = exp_q + 16'd1;
      rsp_cnt_d = rsp_cnt_q + OUTS_W'(1);
      if (rsp_dsc != exp_q) err_d[ERR_DATA] = 1'b1;
    end
    if (st_orphan || ld_orphan) err_d[ERR_ORPHAN] = 1'b1;
    if (st_ovf || ld_ovf)       err_d[ERR_OVF]    = 1'b1;

    if (rsp_fire || (msgst_outs == '0 && msgld_outs == '0)) wd_d = '0;
    else if (wd_q != TIMEOUT_CYC)                            wd_d = wd_q + TIMEOUT_W'(1);
    if (wd_d == TIMEOUT_CYC) err_d[ERR_TIMEOUT] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN:   if (!start) state_d = DRAIN;
      DRAIN: begin
        if (start)                                          state_d = RUN;
        else if (msgst_outs == '0 && msgld_outs == '0)      state_d = DONE;
      end
      DONE:  if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (clr) begin
      exp_q     <= '0;
      rsp_cnt_q <= '0;
      wd_q      <= '0;
      err_q     <= '0;
      state_q   <= IDLE;
    end else begin
      exp_q     <= exp_d;
      rsp_cnt_q <= rsp_cnt_d;
      wd_q      <= wd_d;
      err_q     <= err_d;
      state_q   <= state_d;
    end
  end

  assign msgld_rsp_cnt = rsp_cnt_q;
  assign err_vec       = err_q;
  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == DONE);

endmodule

// File: tb/tb_cdm_msg_rsp_tracker.sv
// Directed bench for cdm_msg_rsp_tracker: a main instance with a short watchdog
// and a 2-bit-counter instance for saturation, driven by shared stimulus.
module tb_cdm_msg_rsp_tracker;

  logic        clk = 1'b0;
  logic        rst, en, start, st_req, ld_req, rsp_vld;
  logic [11:0] cookie;
  logic [15:0] dsc;

  logic       rsp_rdy, busy, done;
  logic [8:0] st_outs, ld_outs, ld_cnt;
  logic [3:0] err;

  logic       s_rsp_rdy, s_busy, s_done;
  logic [1:0] s_st_outs, s_ld_outs, s_ld_cnt;
  logic [3:0] s_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cdm_msg_rsp_tracker #(.OUTS_W(9), .TIMEOUT_W(16), .TIMEOUT_CYC(16'd16)) dut (
    .user_clk(clk), .user_reset(rst), .en(en), .start(start),
    .msgst_req_fire(st_req), .msgld_req_fire(ld_req),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_cookie(cookie), .rsp_dsc(dsc),
    .msgst_outs(st_outs), .msgld_outs(ld_outs), .msgld_rsp_cnt(ld_cnt),
    .busy(busy), .done(done), .err_vec(err)
  );

  cdm_msg_rsp_tracker #(.OUTS_W(2)) dut_s (
    .user_clk(clk), .user_reset(rst), .en(en), .start(start),
    .msgst_req_fire(st_req), .msgld_req_fire(ld_req),
    .rsp_vld(rsp_vld), .rsp_rdy(s_rsp_rdy), .rsp_cookie(cookie), .rsp_dsc(dsc),
    .msgst_outs(s_st_outs), .msgld_outs(s_ld_outs), .msgld_rsp_cnt(s_ld_cnt),
    .busy(s_busy), .done(s_done), .err_vec(s_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; st_req = 1'b0; ld_req = 1'b0;
    rsp_vld = 1'b0; cookie = 12'h0; dsc = 16'h0;

    // reset state
    tick(); tick();
    chk("rst_rdy",     {31'd0, rsp_rdy}, 32'd0);
    chk("rst_st_outs", {23'd0, st_outs}, 32'd0);
    chk("rst_ld_cnt",  {23'd0, ld_cnt},  32'd0);
    chk("rst_err",     {28'd0, err},     32'd0);
    chk("rst_busy",    {31'd0, busy},    32'd0);
    chk("rst_done",    {31'd0, done},    32'd0);
    rst = 1'b0;
    tick();
    chk("run_rdy", {31'd0, rsp_rdy}, 32'd1);

    // 4 MSGLD requests, in-order data 0..3
    ld_req = 1'b1;
    repeat (4) tick();
    ld_req = 1'b0;
    chk("ld4_outs", {23'd0, ld_outs}, 32'd4);
    rsp_vld = 1'b1; cookie = 12'h001;
    dsc = 16'd0; tick();
    dsc = 16'd1; tick();
    chk("ld_half_outs", {23'd0, ld_outs}, 32'd2);
    dsc = 16'd2; cookie = 12'hAB1; tick();
    dsc = 16'd3; tick();
    rsp_vld = 1'b0;
    chk("ld_done_outs", {23'd0, ld_outs}, 32'd0);
    chk("ld_done_cnt",  {23'd0, ld_cnt},  32'd4);
    chk("ld_done_err",  {28'd0, err},     32'd0);

    // data mismatch: 0,1,5 then 3
    do_reset();
    ld_req = 1'b1;
    repeat (4) tick();
    ld_req = 1'b0;
    rsp_vld = 1'b1; cookie = 12'h001;
    dsc = 16'd0; tick();
    dsc = 16'd1; tick();
    chk("mm_pre_err", {28'd0, err}, 32'd0);
    dsc = 16'd5; tick();
    chk("mm_err", {28'd0, err}, 32'h1);
    dsc = 16'd3; tick();
    rsp_vld = 1'b0;
    chk("mm_sticky_err", {28'd0, err},     32'h1);
    chk("mm_cnt",        {23'd0, ld_cnt},  32'd4);
    chk("mm_outs",       {23'd0, ld_outs}, 32'd0);

    // en=0 clears; orphan MSGST ack
    en = 1'b0; tick(); en = 1'b1;
    chk("en_clr_err", {28'd0, err},    32'd0);
    chk("en_clr_cnt", {23'd0, ld_cnt}, 32'd0);
    rsp_vld = 1'b1; cookie = 12'h000; tick();
    rsp_vld = 1'b0;
    chk("orphan_err",  {28'd0, err},     32'h2);
    chk("orphan_outs", {23'd0, st_outs}, 32'd0);
    en = 1'b0; tick(); en = 1'b1;
    st_req = 1'b1; rsp_vld = 1'b1; cookie = 12'h000; tick();
    st_req = 1'b0; rsp_vld = 1'b0;
    chk("same_cyc_err",  {28'd0, err},     32'd0);
    chk("same_cyc_outs", {23'd0, st_outs}, 32'd0);

    // watchdog: one MSGLD request never answered
    do_reset();
    start = 1'b1; tick();
    chk("wd_run_busy", {31'd0, busy}, 32'd1);
    ld_req = 1'b1; tick();
    ld_req = 1'b0; start = 1'b0;
    repeat (15) tick();
    chk("wd_pre_err", {28'd0, err}, 32'd0);
    tick();
    chk("wd_err", {28'd0, err}, 32'h4);
    repeat (3) tick();
    chk("wd_drain_busy", {31'd0, busy}, 32'd1);
    chk("wd_drain_done", {31'd0, done}, 32'd0);
    chk("wd_err_hold",   {28'd0, err},  32'h4);
    start = 1'b1; tick();
    chk("wd_resume_busy", {31'd0, busy},    32'd1);
    chk("wd_resume_outs", {23'd0, ld_outs}, 32'd1);
    start = 1'b0;

    // run / drain / done with 3 MSGST acks
    do_reset();
    chk("fsm_idle_busy", {31'd0, busy}, 32'd0);
    start = 1'b1; st_req = 1'b1;
    repeat (3) tick();
    st_req = 1'b0;
    chk("dr_outs3", {23'd0, st_outs}, 32'd3);
    chk("dr_busy",  {31'd0, busy},    32'd1);
    start = 1'b0; tick();
    rsp_vld = 1'b1; cookie = 12'h0F0;
    repeat (3) tick();
    rsp_vld = 1'b0;
    chk("dr_outs0",      {23'd0, st_outs}, 32'd0);
    chk("dr_still_busy", {31'd0, busy},    32'd1);
    chk("dr_not_done",   {31'd0, done},    32'd0);
    tick();
    chk("dr_done",      {31'd0, done}, 32'd1);
    chk("dr_idle_busy", {31'd0, busy}, 32'd0);
    chk("dr_err",       {28'd0, err},  32'd0);
    start = 1'b1; tick();
    chk("dr_restart_busy", {31'd0, busy}, 32'd1);
    chk("dr_restart_done", {31'd0, done}, 32'd0);
    start = 1'b0;

    // saturation on the 2-bit instance, then reset
    do_reset();
    st_req = 1'b1;
    repeat (4) tick();
    st_req = 1'b0;
    chk("sat_outs",      {30'd0, s_st_outs}, 32'd3);
    chk("sat_err",       {28'd0, s_err},     32'h8);
    chk("wide_outs",     {23'd0, st_outs},   32'd4);
    chk("wide_no_ovf",   {28'd0, err},       32'd0);
    rst = 1'b1; tick();
    chk("sat_rst_outs", {30'd0, s_st_outs},      32'd0);
    chk("sat_rst_err",  {28'd0, s_err},          32'd0);
    chk("sat_rst_fsm",  {30'd0, s_busy, s_done}, 32'd0);
    chk("sat_rst_rdy",  {31'd0, s_rsp_rdy},      32'd0);
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
